// File: rtl/serial_add_sequencer_if.sv
// ============================================================================
// Module   : serial_add_sequencer_if
// Brief    : Operand/result handshakes and full-adder cell link for the
//            bit-serial add controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface serial_add_sequencer_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             cin_in;
   logic             fa_a;
   logic             fa_b;
   logic             fa_cin;
   logic             fa_sum;
   logic             fa_cout;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum_out;
   logic             cout_out;
   logic             busy;

   modport slave (
      input  in_valid, a_in, b_in, cin_in, fa_sum, fa_cout, out_ready,
      output in_ready, fa_a, fa_b, fa_cin, out_valid, sum_out, cout_out, busy
   );

   modport master (
      output in_valid, a_in, b_in, cin_in, fa_sum, fa_cout, out_ready,
      input  in_ready, fa_a, fa_b, fa_cin, out_valid, sum_out, cout_out, busy
   );
endinterface

`default_nettype wire

// File: rtl/serial_add_sequencer.sv
// ============================================================================
// Module   : serial_add_sequencer
// Brief    : Steps an external 1-bit full adder LSB first over WIDTH cycles and
//            returns {cout, sum} over a valid/ready handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_add_sequencer #(
   parameter int WIDTH = 8
) (
   input  wire logic                clk,
   input  wire logic                rst_n,
   input  wire logic                ena,
   serial_add_sequencer_if.slave    bus
);
   localparam int             CW     = $clog2(WIDTH);
   localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum_out;
   logic             r_cout_out;
   logic             w_last;
   logic [WIDTH-1:0] w_sum_shift;

   assign w_last      = (r_cnt == C_LAST);
   assign w_sum_shift = {bus.fa_sum, r_sum[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else if (ena) begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.in_valid)  w_next = S_RUN;
         S_RUN:   if (w_last)        w_next = S_DONE;
         S_DONE:  if (bus.out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Result registers are loaded only on the final bit so they hold the last
   // answer while the next job is shifting through r_sum.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a        <= '0;
         r_b        <= '0;
         r_sum      <= '0;
         r_carry    <= 1'b0;
         r_cnt      <= '0;
         r_sum_out  <= '0;
         r_cout_out <= 1'b0;
      end else if (ena) begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_a     <= bus.a_in;
                  r_b     <= bus.b_in;
                  r_carry <= bus.cin_in;
                  r_cnt   <= '0;
               end
            end
            S_RUN: begin
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_sum   <= w_sum_shift;
               r_carry <= bus.fa_cout;
               r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
               if (w_last) begin
                  r_sum_out  <= w_sum_shift;
                  r_cout_out <= bus.fa_cout;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.in_ready  = (r_state == S_IDLE) & ena;
      bus.out_valid = (r_state == S_DONE);
      bus.busy      = (r_state != S_IDLE);
      bus.fa_a      = (r_state == S_RUN) & r_a[0];
      bus.fa_b      = (r_state == S_RUN) & r_b[0];
      bus.fa_cin    = (r_state == S_RUN) & r_carry;
      bus.sum_out   = r_sum_out;
      bus.cout_out  = r_cout_out;
   end
endmodule

`default_nettype wire

// File: tb/tb_serial_add_sequencer.sv
// ============================================================================
// Module   : tb_serial_add_sequencer
// Brief    : Scoreboard bench for serial_add_sequencer with a behavioural adder cell.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_add_sequencer;
   localparam int WIDTH = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic ena   = 1'b0;
   int   cyc   = 0;
   int   errors = 0;
   int   checks = 0;
   logic [WIDTH:0] exp_q[$];
   logic [WIDTH:0] mon_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_add_sequencer_if #(.WIDTH(WIDTH)) sif ();

   serial_add_sequencer #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .bus   (sif)
   );

   assign sif.fa_sum  = sif.fa_a ^ sif.fa_b ^ sif.fa_cin;
   assign sif.fa_cout = (sif.fa_a & sif.fa_b) | (sif.fa_a & sif.fa_cin) | (sif.fa_b & sif.fa_cin);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && ena && sif.out_valid && sif.out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 64'd1, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("result", {55'd0, sif.cout_out, sif.sum_out}, {55'd0, mon_e});
         end
      end
   end

   // Returns one ns after the accept edge; acc_cyc is the cycle stamp of that edge.
   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic c, input bit hold, output int acc_cyc);
      int n;
      bit ok;
      n  = 0;
      ok = 1'b0;
      sif.a_in     = a;
      sif.b_in     = b;
      sif.cin_in   = c;
      sif.in_valid = 1'b1;
      while (!ok && n < 200) begin
         @(negedge clk);
         if (sif.in_ready) ok = 1'b1;
         else begin
            @(posedge clk);
            n++;
         end
      end
      if (!ok) begin
         check("accept_timeout", 64'd0, 64'd1);
         sif.in_valid = 1'b0;
         acc_cyc = -1;
         return;
      end
      @(posedge clk);
      #1;
      exp_q.push_back({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c});
      acc_cyc = cyc;
      if (!hold) sif.in_valid = 1'b0;
   endtask

   // Returns on the negedge where out_valid is first seen.
   task automatic wait_done();
      int n;
      bit ok;
      n  = 0;
      ok = 1'b0;
      while (!ok && n < 100) begin
         @(negedge clk);
         if (sif.out_valid) ok = 1'b1;
         else begin
            @(posedge clk);
            n++;
         end
      end
      if (!ok) check("done_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      int acc;
      int prev;
      int quiet;
      sif.in_valid  = 1'b0;
      sif.a_in      = '0;
      sif.b_in      = '0;
      sif.cin_in    = 1'b0;
      sif.out_ready = 1'b1;
      ena           = 1'b1;
      rst_n         = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      @(negedge clk);
      check("rst_in_ready",  64'(sif.in_ready),  64'd1);
      check("rst_out_valid", 64'(sif.out_valid), 64'd0);
      check("rst_busy",      64'(sif.busy),      64'd0);
      check("rst_sum_out",   64'(sif.sum_out),   64'd0);
      check("rst_cout_out",  64'(sif.cout_out),  64'd0);
      check("rst_fa",        64'({sif.fa_a, sif.fa_b, sif.fa_cin}), 64'd0);

      @(posedge clk); #1 ena = 1'b0;
      @(negedge clk);
      check("idle_ena0_in_ready", 64'(sif.in_ready), 64'd0);
      @(posedge clk); #1 ena = 1'b1;

      // Job 1: basic add and latency
      send(8'h5A, 8'h33, 1'b0, 1'b0, acc);
      wait_done();
      check("latency_job1", 64'(cyc - acc), 64'd8);
      check("job1_sum", 64'({sif.cout_out, sif.sum_out}), 64'h08D);
      @(posedge clk); #1;

      // Job 2: carry ripples through every bit after bit 0
      send(8'hFF, 8'h01, 1'b0, 1'b0, acc);
      for (int i = 0; i < WIDTH; i++) begin
         @(negedge clk);
         check("fa_cin_bit", 64'(sif.fa_cin), (i == 0) ? 64'd0 : 64'd1);
         @(posedge clk);
      end
      @(negedge clk);
      check("job2_out_valid", 64'(sif.out_valid), 64'd1);
      check("job2_sum", 64'({sif.cout_out, sif.sum_out}), 64'h100);
      @(posedge clk); #1;

      // Job 3: back-pressure holds the result; stray requests ignored
      sif.out_ready = 1'b0;
      send(8'hFF, 8'hFF, 1'b1, 1'b0, acc);
      wait_done();
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         sif.in_valid = 1'b1;
         sif.a_in     = 8'h12;
         sif.b_in     = 8'h34;
         sif.cin_in   = 1'b0;
         @(negedge clk);
         check("hold_out_valid", 64'(sif.out_valid), 64'd1);
         check("hold_result", 64'({sif.cout_out, sif.sum_out}), 64'h1FF);
         check("hold_in_ready", 64'(sif.in_ready), 64'd0);
      end
      @(posedge clk); #1;
      sif.in_valid  = 1'b0;
      sif.out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("after_hold_busy", 64'(sif.busy), 64'd0);
      check("after_hold_keep", 64'({sif.cout_out, sif.sum_out}), 64'h1FF);
      @(posedge clk); #1;

      // Job 4: three enable-low cycles after bit 3 stretch latency by three
      send(8'h9C, 8'h6B, 1'b1, 1'b0, acc);
      repeat (4) @(posedge clk);
      #1 ena = 1'b0;
      @(negedge clk);
      check("ena0_busy",     64'(sif.busy),     64'd1);
      check("ena0_in_ready", 64'(sif.in_ready), 64'd0);
      repeat (3) @(posedge clk);
      #1 ena = 1'b1;
      wait_done();
      check("latency_ena_gap", 64'(cyc - acc), 64'd11);
      @(posedge clk); #1;

      // Job 5: reset aborts mid-job
      send(8'hA5, 8'h5A, 1'b0, 1'b0, acc);
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      void'(exp_q.pop_back());
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("abort_in_ready",  64'(sif.in_ready),  64'd1);
      check("abort_busy",      64'(sif.busy),      64'd0);
      check("abort_result",    64'({sif.cout_out, sif.sum_out}), 64'd0);
      quiet = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (sif.out_valid) quiet++;
      end
      check("abort_no_out_valid", 64'(quiet), 64'd0);
      @(posedge clk); #1;
      send(8'h01, 8'h02, 1'b1, 1'b0, acc);
      wait_done();
      check("latency_after_abort", 64'(cyc - acc), 64'd8);
      check("job5_sum", 64'({sif.cout_out, sif.sum_out}), 64'h004);
      @(posedge clk); #1;

      // Back-to-back stream: one job every WIDTH+2 cycles
      prev = -1;
      for (int j = 0; j < 1000; j++) begin
         send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1, acc);
         if (j > 0) check("b2b_interval", 64'(acc - prev), 64'(WIDTH + 2));
         prev = acc;
      end
      sif.in_valid = 1'b0;
      quiet = 0;
      while (exp_q.size() != 0 && quiet < 100) begin
         @(posedge clk);
         quiet++;
      end
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

`default_nettype wire
